phase_unwrap: RTL and testbench

- Consumes the atan2 angle stream: signed degrees, Q.8 fixed point (256 LSB = 1°), range [-46080, +46080].
- Removes ±360° jumps and produces a continuous (unwrapped) phase.
- Also produces a block-averaged per-sample phase increment, which serves as the frequency estimate.
- Sits directly downstream of atan2 and feeds the loop filter / NCO correction logic.

---
 rtl/phase_unwrap_pkg.sv | 16 +
 rtl/phase_unwrap_delta_wrap.sv | 31 +++
 rtl/phase_unwrap.sv | 146 ++++++++++++++
 tb/tb_phase_unwrap.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_unwrap_pkg.sv
// rtl/phase_unwrap_pkg.sv - shared constants and types for the phase unwrap datapath
package phase_pkg;

    localparam int FRAC_BITS = 8;
    localparam int DEG180_Q8 = 46080;
    localparam int DEG360_Q8 = 92160;
    localparam int PHASE_W   = 32;

    typedef logic signed [PHASE_W-1:0] phase_t;

    typedef enum logic {
        FIRST = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/phase_unwrap_delta_wrap.sv
// rtl/phase_unwrap_delta_wrap.sv - combinational wrapped phase difference (cur - prev folded into (-180, +180])
module phase_delta_wrap
    import phase_pkg::*;
#(
    parameter int PH_W = 32
) (
    input  logic signed [PH_W-1:0] i_cur,
    input  logic signed [PH_W-1:0] i_prev,
    output logic signed [PH_W-1:0] o_delta
);

    localparam logic signed [PH_W:0] W_180 = (PH_W+1)'(DEG180_Q8);
    localparam logic signed [PH_W:0] W_360 = (PH_W+1)'(DEG360_Q8);

    logic signed [PH_W:0] w_diff;
    logic signed [PH_W:0] w_wrapped;

    // One extra bit keeps the raw difference exact; a single +/-360 fold suffices for in-range inputs,
    // and an exact -180 step lands on +180.
    always_comb begin
        w_diff    = {i_cur[PH_W-1], i_cur} - {i_prev[PH_W-1], i_prev};
        w_wrapped = w_diff;
        if (w_diff > W_180) begin
            w_wrapped = w_diff - W_360;
        end else if (w_diff <= -W_180) begin
            w_wrapped = w_diff + W_360;
        end
        o_delta = w_wrapped[PH_W-1:0];
    end

endmodule

// File: rtl/phase_unwrap.sv
// rtl/phase_unwrap.sv - phase unwrapper with block-averaged frequency estimate; PHASE_UNWRAP_SAT_EN selects saturating accumulator
module phase_unwrap
    import phase_pkg::*;
#(
    parameter int PH_W     = 32,
    parameter int ACC_W    = 48,
    parameter int AVG_LOG2 = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic signed [PH_W-1:0]  i_phase_in,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    output logic signed [ACC_W-1:0] o_unwrap_out,
    output logic signed [PH_W-1:0]  o_delta_out,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic signed [PH_W-1:0]  o_freq_out,
    output logic                    o_freq_valid,
    output logic                    o_sat_flag
);

    // Sum of 2^AVG_LOG2 PH_W-bit deltas fits exactly in PH_W+AVG_LOG2 bits.
    localparam int SUM_W = PH_W + AVG_LOG2;

    state_t                  r_state;
    logic signed [PH_W-1:0]  r_prev;
    logic signed [PH_W-1:0]  r_delta;
    logic signed [PH_W-1:0]  r_freq;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [SUM_W-1:0] r_sum;
    logic [AVG_LOG2-1:0]     r_cnt;
    logic                    r_out_valid;
    logic                    r_freq_valid;

    logic signed [PH_W-1:0]  w_delta;
    logic                    w_xfer;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [SUM_W-1:0] w_sum_next;

    phase_delta_wrap #(
        .PH_W (PH_W)
    ) u_delta_wrap (
        .i_cur   (i_phase_in),
        .i_prev  (r_prev),
        .o_delta (w_delta)
    );

    assign o_in_ready = !i_clear && (!r_out_valid || i_out_ready);
    assign w_xfer     = i_in_valid && o_in_ready;
    assign w_sum_next = r_sum + SUM_W'(w_delta);

`ifdef PHASE_UNWRAP_SAT_EN
    logic                    r_sat;
    logic signed [ACC_W:0]   w_acc_wide;
    logic                    w_sat_hit;

    // Detect signed overflow of the accumulator update and clamp to the rail.
    always_comb begin
        w_acc_wide = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_delta);
        w_sat_hit  = (w_acc_wide[ACC_W] != w_acc_wide[ACC_W-1]);
        if (!w_sat_hit) begin
            w_acc_next = w_acc_wide[ACC_W-1:0];
        end else if (w_acc_wide[ACC_W]) begin
            w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    assign o_sat_flag = r_sat;
`else
    assign w_acc_next = r_acc + ACC_W'(w_delta);
    assign o_sat_flag = 1'b0;
`endif

    // FSM, output registers, accumulator and block averager.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= FIRST;
            r_prev       <= '0;
            r_delta      <= '0;
            r_freq       <= '0;
            r_acc        <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_freq_valid <= 1'b0;
`ifdef PHASE_UNWRAP_SAT_EN
            r_sat        <= 1'b0;
`endif
        end else if (i_clear) begin
            // Restart: the next accepted sample re-seeds the accumulator; displayed values are kept.
            r_state      <= FIRST;
            r_prev       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_freq_valid <= 1'b0;
`ifdef PHASE_UNWRAP_SAT_EN
            r_sat        <= 1'b0;
`endif
        end else begin
            r_freq_valid <= 1'b0;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_prev      <= i_phase_in;
                case (r_state)
                    FIRST: begin
                        r_delta <= '0;
                        r_acc   <= ACC_W'(i_phase_in);
                        r_state <= RUN;
                    end
                    default: begin
                        r_delta <= w_delta;
                        r_acc   <= w_acc_next;
`ifdef PHASE_UNWRAP_SAT_EN
                        if (w_sat_hit) begin
                            r_sat <= 1'b1;
                        end
`endif
                        r_cnt <= r_cnt + 1'b1;
                        if (&r_cnt) begin
                            // Arithmetic shift by dropping the low bits rounds toward -inf.
                            r_freq       <= w_sum_next[SUM_W-1:AVG_LOG2];
                            r_freq_valid <= 1'b1;
                            r_sum        <= '0;
                        end else begin
                            r_sum <= w_sum_next;
                        end
                    end
                endcase
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_unwrap_out = r_acc;
    assign o_delta_out  = r_delta;
    assign o_out_valid  = r_out_valid;
    assign o_freq_out   = r_freq;
    assign o_freq_valid = r_freq_valid;

endmodule

// File: tb/tb_phase_unwrap.sv
// tb/tb_phase_unwrap.sv - directed self-checking bench for phase_unwrap
module tb_phase_unwrap;

    logic clk = 1'b0;
    logic rst_n;
    logic i_clear;
    logic signed [31:0] i_phase;
    logic i_valid;
    logic i_out_ready;

    logic               in_ready;
    logic signed [47:0] unwrap;
    logic signed [31:0] delta;
    logic               out_valid;
    logic signed [31:0] freq;
    logic               fv;
    logic               sat;

    logic               in_ready2;
    logic signed [19:0] unwrap2;
    logic signed [31:0] delta2;
    logic               out_valid2;
    logic signed [31:0] freq2;
    logic               fv2;
    logic               sat2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    phase_unwrap #(.PH_W(32), .ACC_W(48), .AVG_LOG2(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_phase_in(i_phase),
        .i_in_valid(i_valid), .o_in_ready(in_ready), .o_unwrap_out(unwrap),
        .o_delta_out(delta), .o_out_valid(out_valid), .i_out_ready(i_out_ready),
        .o_freq_out(freq), .o_freq_valid(fv), .o_sat_flag(sat)
    );

    phase_unwrap #(.PH_W(32), .ACC_W(20), .AVG_LOG2(4)) dut_narrow (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_phase_in(i_phase),
        .i_in_valid(i_valid), .o_in_ready(in_ready2), .o_unwrap_out(unwrap2),
        .o_delta_out(delta2), .o_out_valid(out_valid2), .i_out_ready(i_out_ready),
        .o_freq_out(freq2), .o_freq_valid(fv2), .o_sat_flag(sat2)
    );

    typedef struct {
        bit     clr;
        int     ph;
        int     d;
        longint u;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input int p);
        i_phase     = p;
        i_valid     = 1'b1;
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
    endtask

    // First sample plus 16 counted deltas: a,b alternate for 15 steps, then c.
    task automatic freq_block(input int start, input int a, input int b, input int c,
                              input int exp_f, input string tag);
        int ph;
        int step;
        int pulses;
        ph     = start;
        pulses = 0;
        send(start);
        chk({tag, "_first_delta"}, delta, 0);
        chk({tag, "_first_unwrap"}, unwrap, start);
        pulses += int'(fv);
        for (int i = 0; i < 16; i++) begin
            step = (i == 15) ? c : (((i % 2) == 0) ? a : b);
            ph += step;
            send(ph);
            if (i < 15) begin
                pulses += int'(fv);
            end else begin
                chk({tag, "_fv_last"}, fv, 1);
                chk({tag, "_freq"}, freq, exp_f);
            end
        end
        chk({tag, "_early_pulses"}, pulses, 0);
        @(posedge clk);
        #1;
        chk({tag, "_fv_single"}, fv, 0);
        chk({tag, "_freq_held"}, freq, exp_f);
    endtask

    initial begin
        int p;
        longint exp_narrow;
        bit     exp_sat;

        rst_n       = 1'b0;
        i_clear     = 1'b0;
        i_phase     = 0;
        i_valid     = 1'b0;
        i_out_ready = 1'b0;

`ifdef PHASE_UNWRAP_SAT_EN
        exp_narrow = 524287;
        exp_sat    = 1'b1;
`else
        exp_narrow = -518656;
        exp_sat    = 1'b0;
`endif

        vt = '{
            '{1'b1,  43520,      0,  43520},
            '{1'b0,  46080,   2560,  46080},
            '{1'b0, -43520,   2560,  48640},
            '{1'b1, -43520,      0, -43520},
            '{1'b0, -46080,  -2560, -46080},
            '{1'b0,  43520,  -2560, -48640},
            '{1'b1,      0,      0,      0},
            '{1'b0, -46080,  46080,  46080},
            '{1'b1,      0,      0,      0},
            '{1'b0,  46080,  46080,  46080},
            '{1'b1,      0,      0,      0},
            '{1'b0,  46081, -46079, -46079},
            '{1'b1,      0,      0,      0},
            '{1'b0, -46081,  46079,  46079},
            '{1'b0,  46081,      2,  46081}
        };

        #1;
        chk("rst_unwrap", unwrap, 0);
        chk("rst_delta", delta, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_freq", freq, 0);
        chk("rst_fv", fv, 0);
        chk("rst_sat", sat, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (vt[i].clr) begin
                do_clear();
                chk($sformatf("v%0d_clr_out_valid", i), out_valid, 0);
            end
            send(vt[i].ph);
            chk($sformatf("v%0d_delta", i), delta, vt[i].d);
            chk($sformatf("v%0d_unwrap", i), unwrap, vt[i].u);
            chk($sformatf("v%0d_out_valid", i), out_valid, 1);
        end

        do_clear();
        freq_block(0, 1280, 1280, 1280, 1280, "f_const");
        do_clear();
        freq_block(0, 1, 0, 0, 0, "f_half");
        do_clear();
        freq_block(0, 0, 0, -1, -1, "f_neg");

        // Backpressure: output must hold and input must stall.
        do_clear();
        send(0);
        i_phase     = 2560;
        i_valid     = 1'b1;
        i_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_unwrap", i), unwrap, 0);
        end
        i_out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("bp_after_unwrap", unwrap, 2560);
        chk("bp_after_delta", delta, 2560);
        chk("bp_after_out_valid", out_valid, 1);
        @(posedge clk);
        #1;
        chk("bp_drain_out_valid", out_valid, 0);
        chk("bp_drain_unwrap", unwrap, 2560);
        send(5120);
        chk("bp_next_delta", delta, 2560);
        chk("bp_next_unwrap", unwrap, 5120);

        // Clear mid-block, colliding with a valid sample.
        do_clear();
        send(0);
        send(1280);
        send(2560);
        i_phase = 99999;
        i_valid = 1'b1;
        i_clear = 1'b1;
        #1;
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        i_valid = 1'b0;
        chk("clr_out_valid", out_valid, 0);
        chk("clr_unwrap_held", unwrap, 2560);
        freq_block(5000, 1280, 1280, 1280, 1280, "f_restart");

        // Constant +90 degree steps into a 20-bit accumulator.
        do_clear();
        chk("sat_clear_flag", sat2, 0);
        send(0);
        for (int k = 1; k <= 23; k++) begin
            p = (k * 23040) % 92160;
            if (p > 46080) p -= 92160;
            send(p);
            if (k == 22) begin
                chk("sat_k22_unwrap", unwrap2, 506880);
                chk("sat_k22_flag", sat2, 0);
            end
        end
        chk("sat_k23_unwrap_narrow", unwrap2, exp_narrow);
        chk("sat_k23_flag", sat2, exp_sat);
        chk("sat_k23_unwrap_wide", unwrap, 529920);
        chk("sat_wide_flag", sat, 0);
        do_clear();
        chk("sat_after_clear_flag", sat2, 0);

        // Asynchronous reset mid-block discards everything.
        send(0);
        send(1280);
        send(2560);
        rst_n = 1'b0;
        #1;
        chk("amid_rst_unwrap", unwrap, 0);
        chk("amid_rst_delta", delta, 0);
        chk("amid_rst_out_valid", out_valid, 0);
        chk("amid_rst_freq", freq, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(7000);
        chk("post_rst_first_delta", delta, 0);
        chk("post_rst_unwrap", unwrap, 7000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
